// File: rtl/axi_rd_burst_engine_pkg.sv
// Shared types and constants for the multi-channel AXI read burst engine.
// Optional watchdog is enabled by defining AXI_RD_TIMEOUT_EN.
package axi_rd_burst_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RESP  = 2'b01;
    localparam logic [1:0] ERR_PROTO = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned PAGE_BYTES = 4096;

    function automatic int size_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_rd_channel.sv
// One independent read channel: request capture, 4 KB check, AR issue, R pass-through.
// Watchdog logic exists only when AXI_RD_TIMEOUT_EN is defined.
module axi_rd_channel
    import axi_rd_burst_engine_pkg::*;
#(
    parameter int CH_IDX      = 0,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 7,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [LEN_WIDTH-1:0]  arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int SIZE_LOG2 = size_log2(DATA_WIDTH);
    localparam int BW        = LEN_WIDTH + SIZE_LOG2 + 14;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            err_q, err_d;
    logic                  done_q, done_d;

    logic [BW-1:0] end_byte;
    logic          page_cross, ar_hs, r_hs, last_beat;

    // End offset within the 4 KB page; equal to 4096 still fits.
    assign end_byte   = BW'(req_addr[11:0]) + ((BW'(req_len) + BW'(1)) << SIZE_LOG2);
    assign page_cross = end_byte > BW'(PAGE_BYTES);

    assign req_ready = (state_q == ST_IDLE);
    assign arvalid   = (state_q == ST_ADDR);
    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arid      = ID_WIDTH'(CH_IDX);
    assign arsize    = 3'(SIZE_LOG2);
    assign arburst   = BURST_INCR;
    assign rready    = (state_q == ST_DATA) && out_ready;
    assign out_valid = (state_q == ST_DATA) && rvalid;
    assign out_data  = rdata;
    assign last_beat = (cnt_q == len_q);
    assign out_last  = out_valid && last_beat;
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign done      = done_q;
    assign err_code  = err_q;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`else
    localparam int unused_tmo = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    if (page_cross) begin
                        err_d  = ERR_PROTO;
                        done_d = 1'b1;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (rresp != RESP_OKAY && err_q == ERR_NONE) err_d = ERR_RESP;
                    // Either end condition closes the burst; disagreement is a protocol error.
                    if (rlast || last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (rlast != last_beat) err_d = ERR_PROTO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXI_RD_TIMEOUT_EN
        wdog_d = '0;
        if (state_q != ST_IDLE && !ar_hs && !r_hs) begin
            if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                err_d   = ERR_TMO;
                done_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`endif

endmodule

// File: rtl/axi_rd_burst_engine.sv
// Top of the multi-channel AXI read burst engine: slices flat vectors per channel.
// Define AXI_RD_TIMEOUT_EN to build the per-channel watchdog.
module axi_rd_burst_engine
    import axi_rd_burst_engine_pkg::*;
#(
    parameter int CH          = 2,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 7,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH-1:0]            req_valid,
    output logic [CH-1:0]            req_ready,
    input  logic [CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [CH*LEN_WIDTH-1:0]  req_len,
    output logic [CH-1:0]            out_valid,
    output logic [CH*DATA_WIDTH-1:0] out_data,
    output logic [CH-1:0]            out_last,
    input  logic [CH-1:0]            out_ready,
    output logic [CH-1:0]            done,
    output logic [CH*2-1:0]          err_code,
    output logic [CH*ID_WIDTH-1:0]   arid_m_inf,
    output logic [CH*ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [CH*LEN_WIDTH-1:0]  arlen_m_inf,
    output logic [CH*3-1:0]          arsize_m_inf,
    output logic [CH*2-1:0]          arburst_m_inf,
    output logic [CH-1:0]            arvalid_m_inf,
    input  logic [CH-1:0]            arready_m_inf,
    input  logic [CH*ID_WIDTH-1:0]   rid_m_inf,
    input  logic [CH*DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [CH*2-1:0]          rresp_m_inf,
    input  logic [CH-1:0]            rlast_m_inf,
    input  logic [CH-1:0]            rvalid_m_inf,
    output logic [CH-1:0]            rready_m_inf
);

    // Each channel owns its own ID, so returned rid carries no information.
    logic unused_rid;
    assign unused_rid = ^rid_m_inf;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        axi_rd_channel #(
            .CH_IDX      (g),
            .ID_WIDTH    (ID_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .LEN_WIDTH   (LEN_WIDTH),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .req_len   (req_len[g*LEN_WIDTH +: LEN_WIDTH]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .out_last  (out_last[g]),
            .out_ready (out_ready[g]),
            .done      (done[g]),
            .err_code  (err_code[g*2 +: 2]),
            .arid      (arid_m_inf[g*ID_WIDTH +: ID_WIDTH]),
            .araddr    (araddr_m_inf[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .arlen     (arlen_m_inf[g*LEN_WIDTH +: LEN_WIDTH]),
            .arsize    (arsize_m_inf[g*3 +: 3]),
            .arburst   (arburst_m_inf[g*2 +: 2]),
            .arvalid   (arvalid_m_inf[g]),
            .arready   (arready_m_inf[g]),
            .rdata     (rdata_m_inf[g*DATA_WIDTH +: DATA_WIDTH]),
            .rresp     (rresp_m_inf[g*2 +: 2]),
            .rlast     (rlast_m_inf[g]),
            .rvalid    (rvalid_m_inf[g]),
            .rready    (rready_m_inf[g])
        );
    end

endmodule

// File: tb/tb_axi_rd_burst_engine.sv
// Scoreboard bench: stimulus pushes expected AR/beat/completion records, a monitor pops them.
`timescale 1ns/1ps
module tb_axi_rd_burst_engine;
    import axi_rd_burst_engine_pkg::*;

    localparam int CH = 2, IDW = 4, DW = 16, AW = 32, LW = 7, TMO = 20;
    localparam int RST_W = 8 * CH + CH * AW + CH * LW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [CH-1:0]     req_valid = '0, req_ready;
    logic [CH*AW-1:0]  req_addr = '0;
    logic [CH*LW-1:0]  req_len = '0;
    logic [CH-1:0]     out_valid, out_last, done;
    logic [CH-1:0]     out_ready = '1;
    logic [CH*DW-1:0]  out_data;
    logic [CH*2-1:0]   err_code;
    logic [CH*IDW-1:0] arid_m_inf;
    logic [CH*AW-1:0]  araddr_m_inf;
    logic [CH*LW-1:0]  arlen_m_inf;
    logic [CH*3-1:0]   arsize_m_inf;
    logic [CH*2-1:0]   arburst_m_inf;
    logic [CH-1:0]     arvalid_m_inf, rready_m_inf;
    logic [CH-1:0]     arready_m_inf = '1;
    logic [CH*IDW-1:0] rid_m_inf = '1;
    logic [CH*DW-1:0]  rdata_m_inf = '0;
    logic [CH*2-1:0]   rresp_m_inf = '0;
    logic [CH-1:0]     rlast_m_inf = '0, rvalid_m_inf = '0;

    always #5 clk = ~clk;

    axi_rd_burst_engine #(.CH(CH), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                          .LEN_WIDTH(LW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .done(done), .err_code(err_code),
        .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
        .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf), .arvalid_m_inf(arvalid_m_inf),
        .arready_m_inf(arready_m_inf), .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf),
        .rresp_m_inf(rresp_m_inf), .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf),
        .rready_m_inf(rready_m_inf));

    typedef struct { int ch; logic [AW-1:0] addr; logic [LW-1:0] len; } ar_t;
    typedef struct { int ch; logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int ch; logic [1:0] err; bit lat; } cpl_t;
    ar_t aq[$];
    beat_t bq[$];
    cpl_t cq[$];

    int checks = 0, passed = 0, cyc = 0;
    int last_hs_cyc [CH];
    // Slave model controls, written by the stimulus process.
    bit       arready_en [CH] = '{default: 1'b1};
    bit       tgl        [CH] = '{default: 1'b0};
    int       sl_bad     [CH] = '{default: -1};
    int       sl_rlast_at[CH] = '{default: -1};
    logic [7:0] sl_tag   [CH] = '{default: 8'h00};
    bit       sl_busy    [CH] = '{default: 1'b0};
    int       sl_beat    [CH] = '{default: 0};
    int       sl_last    [CH] = '{default: 0};

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(string nm);
        checks++;
        $display("FAIL %s: no matching expectation", nm);
    endtask

    function automatic int n_ch(int c, int kind);
        int n = 0;
        if (kind == 0) foreach (aq[i]) if (aq[i].ch == c) n++;
        if (kind == 1) foreach (bq[i]) if (bq[i].ch == c) n++;
        if (kind == 2) foreach (cq[i]) if (cq[i].ch == c) n++;
        return n;
    endfunction

    task automatic check_ar(int c);
        int idx = -1;
        foreach (aq[i]) if (idx < 0 && aq[i].ch == c) idx = i;
        if (idx < 0) begin fail("ar_unexpected"); return; end
        chk("ar_fields", 128'({araddr_m_inf[c*AW +: AW], arlen_m_inf[c*LW +: LW], arsize_m_inf[c*3 +: 3],
                               arburst_m_inf[c*2 +: 2], arid_m_inf[c*IDW +: IDW]}),
                         128'({aq[idx].addr, aq[idx].len, 3'd1, 2'b01, 4'(c)}));
        aq.delete(idx);
    endtask

    task automatic check_beat(int c);
        int idx = -1;
        foreach (bq[i]) if (idx < 0 && bq[i].ch == c) idx = i;
        last_hs_cyc[c] = cyc;
        if (idx < 0) begin fail("beat_unexpected"); return; end
        chk("beat", 128'({out_data[c*DW +: DW], out_last[c]}), 128'({bq[idx].data, bq[idx].last}));
        bq.delete(idx);
    endtask

    task automatic check_cpl(int c);
        int idx = -1;
        foreach (cq[i]) if (idx < 0 && cq[i].ch == c) idx = i;
        if (idx < 0) begin fail("done_unexpected"); return; end
        chk("err_code", 128'(err_code[c*2 +: 2]), 128'(cq[idx].err));
        if (cq[idx].lat) chk("done_latency", 128'(cyc - last_hs_cyc[c]), 128'(1));
        cq.delete(idx);
    endtask

    task automatic drive_slave();
        for (int c = 0; c < CH; c++) begin
            arready_m_inf[c]        = arready_en[c];
            rvalid_m_inf[c]         = sl_busy[c];
            rdata_m_inf[c*DW +: DW] = {sl_tag[c], 8'(sl_beat[c])};
            rresp_m_inf[c*2 +: 2]   = (sl_busy[c] && sl_beat[c] == sl_bad[c]) ? 2'b10 : 2'b00;
            rlast_m_inf[c]          = sl_busy[c] && sl_beat[c] == sl_last[c];
        end
    endtask

    // Monitor at negedge, slave model and out_ready driver just after posedge.
    initial begin : p_slave_mon
        bit arh [CH];
        bit rh  [CH];
        logic [LW-1:0] arl [CH];
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                arh[c] = arvalid_m_inf[c] && arready_m_inf[c];
                rh[c]  = rvalid_m_inf[c] && rready_m_inf[c];
                arl[c] = arlen_m_inf[c*LW +: LW];
                if (arh[c]) check_ar(c);
                if (out_valid[c]) chk("rready_mirror", 128'(rready_m_inf[c]), 128'(out_ready[c]));
                if (out_valid[c] && out_ready[c]) check_beat(c);
                if (done[c]) check_cpl(c);
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < CH; c++) begin
                if (!rst_n) sl_busy[c] = 1'b0;
                else if (arh[c]) begin
                    sl_busy[c] = 1'b1;
                    sl_beat[c] = 0;
                    sl_last[c] = (sl_rlast_at[c] >= 0) ? sl_rlast_at[c] : int'(arl[c]);
                end else if (rh[c]) begin
                    if (sl_beat[c] == sl_last[c]) sl_busy[c] = 1'b0;
                    else sl_beat[c]++;
                end
                out_ready[c] = tgl[c] ? ~out_ready[c] : 1'b1;
            end
            drive_slave();
        end
    end

    task automatic issue(int c, logic [AW-1:0] a, logic [LW-1:0] l, logic [1:0] err,
                         int nb, bit has_ar, logic [7:0] tag);
        int k;
        sl_tag[c] = tag;
        if (has_ar) aq.push_back('{c, a, l});
        for (int i = 0; i < nb; i++) bq.push_back('{c, {tag, 8'(i)}, (i == int'(l))});
        cq.push_back('{c, err, nb > 0});
        @(posedge clk);
        #1;
        req_valid[c] = 1'b1;
        req_addr[c*AW +: AW] = a;
        req_len[c*LW +: LW] = l;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[c]) break;
        end
        chk("req_accept", 128'(k < 50), 128'(1));
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
    endtask

    task automatic wait_done(int c);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (n_ch(c, 2) == 0) break;
        end
        chk("completion_in_time", 128'(k < 400), 128'(1));
        chk("beats_left", 128'(n_ch(c, 1)), 128'(0));
    endtask

    task automatic chk_reset_outs(string nm);
        chk(nm, 128'({req_ready, arvalid_m_inf, rready_m_inf, out_valid, out_last, done, err_code,
                      araddr_m_inf, arlen_m_inf}),
                128'({{CH{1'b1}}, {(RST_W - CH){1'b0}}}));
    endtask

    initial begin : p_main
        int k;
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic burst and an exact page fit.
        issue(0, 32'h1000, 7'd3, ERR_NONE, 4, 1'b1, 8'h11);
        wait_done(0);
        issue(0, 32'h0FF8, 7'd3, ERR_NONE, 4, 1'b1, 8'h22);
        wait_done(0);

        // 4 KB crossing: no AR, protocol error.
        issue(0, 32'h0FFC, 7'd3, ERR_PROTO, 0, 1'b0, 8'h33);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen |= arvalid_m_inf[0];
        end
        chk("no_arvalid_on_cross", 128'(seen), 128'(0));
        wait_done(0);

        // Backpressure on ch0 with ch1 running concurrently.
        tgl[0] = 1'b1;
        fork
            issue(0, 32'h2000, 7'd5, ERR_NONE, 6, 1'b1, 8'hA0);
            issue(1, 32'h3040, 7'd7, ERR_NONE, 8, 1'b1, 8'hB1);
        join
        fork
            wait_done(0);
            wait_done(1);
        join
        tgl[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Error response on beat 2, then early rlast.
        sl_bad[1] = 2;
        issue(1, 32'h0400, 7'd3, ERR_RESP, 4, 1'b1, 8'hC2);
        wait_done(1);
        sl_bad[1] = -1;
        sl_rlast_at[0] = 1;
        issue(0, 32'h0500, 7'd3, ERR_PROTO, 2, 1'b1, 8'hD3);
        wait_done(0);
        sl_rlast_at[0] = -1;
        chk("idle_after_proto", 128'(req_ready[0]), 128'(1));

        // Reset during beat 2.
        issue(0, 32'h0600, 7'd3, ERR_NONE, 4, 1'b1, 8'h66);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sl_busy[0] && sl_beat[0] == 2) break;
        end
        chk("reached_beat2", 128'(k < 100), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("reset_mid_burst");
        aq.delete();
        bq.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rready_after_reset", 128'(rready_m_inf[0]), 128'(0));
        issue(0, 32'h0700, 7'd1, ERR_NONE, 2, 1'b1, 8'h77);
        wait_done(0);

        // Stalled address channel.
        arready_en[0] = 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
        issue(0, 32'h0800, 7'd0, ERR_TMO, 0, 1'b0, 8'h88);
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done[0]) break;
        end
        chk("timeout_cycles", 128'(k), 128'(TMO));
        chk("arvalid_after_tmo", 128'(arvalid_m_inf[0]), 128'(0));
        arready_en[0] = 1'b1;
        wait_done(0);
`else
        issue(0, 32'h0800, 7'd0, ERR_NONE, 1, 1'b1, 8'h88);
        repeat (100) @(negedge clk);
        chk("still_in_addr", 128'({arvalid_m_inf[0], req_ready[0]}), 128'(2'b10));
        arready_en[0] = 1'b1;
        wait_done(0);
`endif

        repeat (3) @(negedge clk);
        chk("ar_queue_empty", 128'(aq.size()), 128'(0));
        chk("beat_queue_empty", 128'(bq.size()), 128'(0));
        chk("cpl_queue_empty", 128'(cq.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_engine.md
AXI_RD_BURST_ENGINE -- requirements
Module: axi_rd_burst_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CH, 2, number of independent read channels
- ID_WIDTH, 4, AXI ID width
- DATA_WIDTH, 16, beat width; power of 2, at least 8
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 7, arlen width
- TIMEOUT_CYC, 2000, watchdog limit

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  CH  request strobe
- req_ready  out  CH  channel idle
- req_addr  in  CH*ADDR_WIDTH  byte start address
- req_len  in  CH*LEN_WIDTH  beats-1
- out_valid  out  CH  data beat valid
- out_data  out  CH*DATA_WIDTH  beat data
- out_last  out  CH  final beat
- out_ready  in  CH  consumer ready
- done  out  CH  one-cycle completion pulse
- err_code  out  CH*2  sticky status
- arid_m_inf / araddr_m_inf / arlen_m_inf / arsize_m_inf / arburst_m_inf / arvalid_m_inf  out  CH*{ID_WIDTH, ADDR_WIDTH, LEN_WIDTH, 3, 2, 1}  AXI read address channel
- arready_m_inf  in  CH  AXI read address ready
- rid_m_inf / rdata_m_inf / rresp_m_inf / rlast_m_inf / rvalid_m_inf  in  CH*{ID_WIDTH, DATA_WIDTH, 2, 1, 1}  AXI read data channel
- rready_m_inf  out  CH  AXI read data ready

Function
REQ-003 Each channel SHALL run an independent FSM with states IDLE, ADDR, DATA; no channel stalls another.
REQ-004 req_ready SHALL be 1 only in IDLE. A request is accepted on req_valid&&req_ready; addr and len are registered, and err_code clears to 00 in that same cycle.
REQ-005 On acceptance, if addr[11:0] + (len+1)*(DATA_WIDTH/8) > 4096, the channel SHALL stay in IDLE, set err_code=10, and pulse done next cycle with no AXI traffic; otherwise it SHALL go to ADDR.
REQ-006 In ADDR, the channel SHALL:
- hold arvalid=1 with stable araddr, arlen=len, arid=channel index, arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR);
- move to DATA on arvalid&&arready;
- drive arvalid=0 in every other state.
REQ-007 In DATA, rready SHALL equal out_ready, out_valid SHALL equal rvalid, and out_data SHALL equal rdata combinationally (zero-cycle pass-through).
REQ-008 A beat counter SHALL reset to 0 on entry to DATA and increment on each rvalid&&rready.
REQ-009 out_last SHALL be 1 on the beat where count==len.
REQ-010 The burst SHALL end on the first handshaked beat where rlast=1 or count==len. If those two disagree, err_code SHALL be set to 10.
REQ-011 rresp!=2'b00 on any beat SHALL set err_code=01 unless err_code is already nonzero (first error wins). rid SHALL be ignored.
REQ-012 At burst end the FSM SHALL return to IDLE, and done SHALL pulse 1 in the following cycle.
REQ-013 A new request SHALL be accepted no earlier than the cycle after the return to IDLE.
REQ-014 err_code SHALL hold its value until the next accepted request.

Reset
REQ-015 On rst_n=0 (asynchronous, any state, including mid-burst), every FSM SHALL go to IDLE, counters clear, and outputs reset to:
- req_ready=1
- arvalid=0, rready=0
- out_valid=0, out_last=0
- done=0, err_code=00
- araddr=0, arlen=0
REQ-016 After reset, no residual beat of an aborted burst SHALL be forwarded: rready=0 until a new DATA state is entered.

Configuration
REQ-017 With AXI_RD_TIMEOUT_EN defined, each channel SHALL:
- count consecutive cycles in ADDR or DATA without an ar or r handshake, clearing the count on any handshake;
- on reaching TIMEOUT_CYC, set err_code=11, go to IDLE, drop arvalid/rready, and pulse done.
REQ-018 Without AXI_RD_TIMEOUT_EN, no watchdog logic SHALL exist, and a channel SHALL wait indefinitely.

Structure
REQ-019 A shared package SHALL hold:
- FSM state enum;
- err_code constants (ERR_NONE=00, ERR_RESP=01, ERR_PROTO=10, ERR_TMO=11);
- AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00).
REQ-020 Per-channel logic SHALL live in sub-module axi_rd_channel, instantiated CH times via generate; the top only slices vectors.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic burst: ch0 req addr=0x1000, len=3, DATA_WIDTH=16 -> araddr=0x1000, arlen=3, arsize=1, arburst=01, arid=0; 4 beats out, out_last on 4th, done 1 cycle later, err=00.
- 4 KB boundary: req addr=0x0FFC, len=3 (8 bytes) -> no arvalid, err=10, done pulse.
- Backpressure and concurrency: out_ready toggled 1/0 each cycle while ch1 runs concurrently -> rready mirrors out_ready, no beat lost or duplicated, channels independent.
- Error response and protocol mismatch: rresp=10 on beat 2 -> err=01 while the burst completes; rlast early at beat 1 of len=3 -> err=10, IDLE.
- Reset mid-burst: rst_n low during DATA beat 2 -> all outputs at reset values immediately; the next request completes normally.
- Timeout (AXI_RD_TIMEOUT_EN, TIMEOUT_CYC=20): arready held 0 -> err=11 and done at cycle 20; without the macro, still in ADDR at cycle 100.
